// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - sequential ALU: single-cycle logic/add ops, shift-add multiply, restoring divide
// Divider is present only when ALU_SEQ_DIV_EN is defined; otherwise op 1001 reports err like any illegal op.
module alu_seq #(
   parameter int N = 32
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         start,
   input  logic [3:0]   op,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic         ready,
   output logic         valid,
   output logic [N-1:0] y,
   output logic [N-1:0] yhi,
   output logic         cout,
   output logic         zf,
   output logic         err
);

   localparam int CW = $clog2(N + 1);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic [N-1:0]  acc_hi, acc_lo, opd;

   logic [N-1:0]  bb, sc_y, res_y;
   logic [N:0]    sum;
   logic          sc_cout;
   logic          is_long, illegal;

   always_comb begin
      bb      = op[2] ? ~b : b;
      sum     = {1'b0, a} + {1'b0, bb} + {{N{1'b0}}, op[2]};
      sc_cout = 1'b0;
      case (op[1:0])
         2'b00:   sc_y = a & bb;
         2'b01:   sc_y = a | bb;
         2'b10:   begin sc_y = sum[N-1:0]; sc_cout = sum[N]; end
         default: begin sc_y = {{(N-1){1'b0}}, sum[N-1]}; sc_cout = sum[N]; end
      endcase
`ifdef ALU_SEQ_DIV_EN
      is_long = (op == 4'b1000) || (op == 4'b1001);
`else
      is_long = (op == 4'b1000);
`endif
      illegal = op[3] & ~is_long;
      res_y   = illegal ? '0 : sc_y;
   end

   // One iteration step: acc_lo holds multiplier / quotient bits, acc_hi partial product / remainder.
   logic [N:0]   mul_sum;
   logic [N-1:0] nxt_hi, nxt_lo;
   logic         div_zero;
`ifdef ALU_SEQ_DIV_EN
   logic         is_div;
   logic [N:0]   div_sh, div_diff;
   logic         div_ge;
`endif

   always_comb begin
      mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opd} : {(N+1){1'b0}});
      nxt_hi   = mul_sum[N:1];
      nxt_lo   = {mul_sum[0], acc_lo[N-1:1]};
      div_zero = 1'b0;
`ifdef ALU_SEQ_DIV_EN
      div_sh   = {acc_hi, acc_lo[N-1]};
      div_diff = div_sh - {1'b0, opd};
      div_ge   = (div_sh >= {1'b0, opd});
      if (is_div) begin
         // A zero divisor always "fits", leaving all-ones quotient and remainder == a.
         nxt_hi   = div_ge ? div_diff[N-1:0] : div_sh[N-1:0];
         nxt_lo   = {acc_lo[N-2:0], div_ge};
         div_zero = (opd == '0);
      end
`endif
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state  <= IDLE;
         ready  <= 1'b1;
         valid  <= 1'b0;
         y      <= '0;
         yhi    <= '0;
         cout   <= 1'b0;
         zf     <= 1'b1;
         err    <= 1'b0;
         cnt    <= '0;
         acc_hi <= '0;
         acc_lo <= '0;
         opd    <= '0;
`ifdef ALU_SEQ_DIV_EN
         is_div <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: if (start) begin
               ready <= 1'b0;
               cnt   <= '0;
               if (is_long) begin
                  state  <= BUSY;
                  acc_hi <= '0;
                  acc_lo <= op[0] ? a : b;
                  opd    <= op[0] ? b : a;
`ifdef ALU_SEQ_DIV_EN
                  is_div <= op[0];
`endif
               end else begin
                  state <= DONE;
                  valid <= 1'b1;
                  y     <= res_y;
                  yhi   <= '0;
                  cout  <= illegal ? 1'b0 : sc_cout;
                  zf    <= (res_y == '0);
                  err   <= illegal;
               end
            end
            BUSY: begin
               acc_hi <= nxt_hi;
               acc_lo <= nxt_lo;
               cnt    <= cnt + 1'b1;
               if (cnt == CW'(N - 1)) begin
                  state <= DONE;
                  valid <= 1'b1;
                  y     <= nxt_lo;
                  yhi   <= nxt_hi;
                  cout  <= 1'b0;
                  zf    <= (nxt_lo == '0);
                  err   <= div_zero;
               end
            end
            default: begin
               state <= IDLE;
               valid <= 1'b0;
               ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - self-checking bench for alu_seq (N=32) against an arithmetic reference model
// Op 1001 expectations follow ALU_SEQ_DIV_EN the same way the design does.
module tb_alu_seq;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        start;
   logic [3:0]  op;
   logic [31:0] a, b;
   logic        ready, valid, cout, zf, err;
   logic [31:0] y, yhi;

   int tests = 0;
   int fails = 0;
   int busy_ready_bad = 0;
   int hold_bad = 0;
   int valid_bad = 0;
   logic [31:0] prev_y = '0;

   alu_seq #(.N(32)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .op(op), .a(a), .b(b),
      .ready(ready), .valid(valid), .y(y), .yhi(yhi), .cout(cout), .zf(zf), .err(err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model(input logic [3:0] o, input logic [31:0] aa, input logic [31:0] bv,
                        output logic [31:0] ey, output logic [31:0] eyhi,
                        output logic ec, output logic ez, output logic ee,
                        output logic cchk, output int elat);
      logic [63:0] wide;
      logic [31:0] d;
      ey = '0; eyhi = '0; ec = 1'b0; ee = 1'b0; cchk = 1'b1; elat = 1;
      d = aa - bv;
      wide = 64'(aa) + 64'(bv);
      case (o)
         4'b0000: begin ey = aa & bv;  cchk = 1'b0; end
         4'b0001: begin ey = aa | bv;  cchk = 1'b0; end
         4'b0100: begin ey = aa & ~bv; cchk = 1'b0; end
         4'b0101: begin ey = aa | ~bv; cchk = 1'b0; end
         4'b0010: begin ey = wide[31:0]; ec = wide[32]; end
         4'b0011: begin ey = {31'b0, wide[31]}; ec = wide[32]; end
         4'b0110: begin ey = d; ec = (aa >= bv); end
         4'b0111: begin ey = {31'b0, d[31]}; ec = (aa >= bv); end
         4'b1000: begin
            wide = 64'(aa) * 64'(bv);
            ey = wide[31:0]; eyhi = wide[63:32]; elat = 33;
         end
`ifdef ALU_SEQ_DIV_EN
         4'b1001: begin
            elat = 33;
            if (bv == 0) begin ey = '1; eyhi = aa; ee = 1'b1; end
            else begin ey = aa / bv; eyhi = aa % bv; end
         end
`endif
         default: ee = 1'b1;
      endcase
      ez = (ey == 0);
   endtask

   task automatic run_op(input string tag, input logic [3:0] o, input logic [31:0] aa, input logic [31:0] bv);
      logic [31:0] ey, eyhi;
      logic ec, ez, ee, cchk;
      int elat, lat, guard;
      model(o, aa, bv, ey, eyhi, ec, ez, ee, cchk, elat);
      guard = 0;
      @(negedge clk);
      while (ready !== 1'b1 && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      start = 1'b1; op = o; a = aa; b = bv;
      @(posedge clk); #1;
      start = 1'b0;
      lat = 1;
      // Inputs are scrambled and start re-pulsed while busy; none of it may be taken.
      while (valid !== 1'b1 && lat < 100) begin
         if (ready !== 1'b0) busy_ready_bad++;
         if (y !== prev_y) hold_bad++;
         start = 1'($urandom_range(0, 1));
         op = 4'($urandom);
         a = $urandom;
         b = $urandom;
         @(posedge clk); #1;
         lat++;
      end
      start = 1'b0;
      check({tag, " latency"}, 64'(lat), 64'(elat));
      check({tag, " y"}, 64'(y), 64'(ey));
      check({tag, " yhi"}, 64'(yhi), 64'(eyhi));
      check({tag, " zf"}, 64'(zf), 64'(ez));
      check({tag, " err"}, 64'(err), 64'(ee));
      if (cchk) check({tag, " cout"}, 64'(cout), 64'(ec));
      prev_y = y;
      @(posedge clk); #1;
      check({tag, " valid pulse"}, 64'(valid), 64'(0));
      check({tag, " ready back"}, 64'(ready), 64'(1));
      check({tag, " y held"}, 64'(y), 64'(prev_y));
   endtask

   initial begin
      reset_n = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset ready", 64'(ready), 64'(1));
      check("reset valid", 64'(valid), 64'(0));
      check("reset y", 64'(y), 64'(0));
      check("reset yhi", 64'(yhi), 64'(0));
      check("reset zf", 64'(zf), 64'(1));
      check("reset err", 64'(err), 64'(0));
      check("reset cout", 64'(cout), 64'(0));
      @(negedge clk);
      reset_n = 1'b1;

      run_op("add wrap", 4'b0010, 32'hFFFF_FFFF, 32'd1);
      run_op("slt neg", 4'b0111, 32'hFFFF_FFFF, 32'd1);
      run_op("sub equal", 4'b0110, 32'd5, 32'd5);
      run_op("and", 4'b0000, 32'hF0F0_1234, 32'h0FF0_FFFF);
      run_op("or notb", 4'b0101, 32'h0000_00F0, 32'hFFFF_FF0F);
      run_op("msb of sum", 4'b0011, 32'h4000_0000, 32'h4000_0000);
      run_op("mulu", 4'b1000, 32'hFFFF_FFFF, 32'd2);
      run_op("divu", 4'b1001, 32'd100, 32'd7);
      run_op("divu by zero", 4'b1001, 32'd100, 32'd0);
      run_op("add after div", 4'b0010, 32'd10, 32'd20);
      run_op("mulu before reset", 4'b1000, 32'h1234_5678, 32'h9ABC_DEF0);

      // Abort a multiply ten cycles into BUSY; reset must take effect without a clock edge.
      @(negedge clk);
      start = 1'b1; op = 4'b1000; a = 32'hFFFF_FFFF; b = 32'd3;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (10) @(posedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      check("abort y", 64'(y), 64'(0));
      check("abort yhi", 64'(yhi), 64'(0));
      check("abort ready", 64'(ready), 64'(1));
      check("abort valid", 64'(valid), 64'(0));
      prev_y = '0;
      repeat (3) begin
         @(negedge clk);
         if (valid !== 1'b0) valid_bad++;
      end
      reset_n = 1'b1;
      repeat (40) begin
         @(negedge clk);
         if (valid !== 1'b0) valid_bad++;
      end
      check("no valid after abort", 64'(valid_bad), 64'(0));
      run_op("add after abort", 4'b0010, 32'd2, 32'd3);

      run_op("illegal 1100", 4'b1100, 32'd3, 32'd4);
      run_op("legal clears err", 4'b0001, 32'd3, 32'd4);

      for (int i = 0; i < 40; i++) begin
         run_op("random", 4'($urandom_range(0, 15)), $urandom, $urandom);
      end
      run_op("zero operands", 4'b1000, 32'd0, 32'hDEAD_BEEF);

      check("ready low while busy", 64'(busy_ready_bad), 64'(0));
      check("outputs held while busy", 64'(hold_bad), 64'(0));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter N, default 32, meaning operand/result width in bits (legal N >= 4).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port start  input  1  request; accepted on a rising edge where start=1 and ready=1.
REQ-005 SHALL have port op  input  4  operation code, sampled at accept.
REQ-006 SHALL have ports a, b  input  N  operands, sampled at accept.
REQ-007 SHALL have port ready  output  1  high only in IDLE.
REQ-008 SHALL have port valid  output  1  one-cycle pulse marking new results.
REQ-009 SHALL have ports y, yhi  output  N  result low word / high word (product high, remainder).
REQ-010 SHALL have ports cout, zf, err  output  1 each  adder carry-out, y==0, illegal op or divide-by-zero.

Function
REQ-011 SHALL decode op[3]=0 as single-cycle: op[2]=1 selects ~b as BB with adder carry-in 1, else BB=b with carry-in 0; op[1:0]: 00 a&BB, 01 a|BB, 10 a+BB+cin, 11 y={N-1 zeros, MSB of a+BB+cin}.
REQ-012 SHALL implement SLT (op=0111) as the raw sum MSB, with no overflow correction.
REQ-013 SHALL decode op=1000 as unsigned multiply: {yhi,y}=a*b, 2N-bit exact, by shift-add, one bit per cycle.
REQ-014 SHALL decode op=1001 as unsigned restoring divide: y=a/b, yhi=a%b, one quotient bit per cycle.
REQ-015 SHALL treat op 1010-1111 as illegal: y=yhi=0, err=1, single-cycle latency.
REQ-016 SHALL use FSM states IDLE, BUSY, DONE: IDLE->DONE on accept of single-cycle/illegal op; IDLE->BUSY on accept of mul/div; BUSY->DONE after exactly N iterations; DONE->IDLE unconditionally.
REQ-017 SHALL assert valid only in DONE: latency 1 cycle after accept for single-cycle ops, N+1 cycles for mul/div; max one accept per 2 cycles.
REQ-018 SHALL ignore start and all input changes while ready=0; operands are latched at accept.
REQ-019 SHALL hold y, yhi, cout, zf, err stable from valid until the next valid.
REQ-020 SHALL set yhi=0 for single-cycle ops, cout=0 for mul/div/illegal, zf from y only.
REQ-021 SHALL on divide with b=0 return y=all ones, yhi=a, err=1, still N+1 cycle latency.
REQ-022 SHALL clear err on every valid of a legal op with nonzero divisor.

Reset
REQ-023 SHALL on reset_n=0, asynchronously: state IDLE, ready=1, valid=0, y=yhi=0, cout=0, zf=1, err=0, iteration counter 0.
REQ-024 SHALL abort any in-flight mul/div on reset with no valid produced; first accept permitted on first edge after release.

Configuration
REQ-025 SHALL compile the divider only when macro ALU_SEQ_DIV_EN is defined; with it, op 1001 behaves per REQ-014/021.
REQ-026 SHALL without ALU_SEQ_DIV_EN treat op 1001 as illegal per REQ-015, with no divider logic synthesised.

Verification (N=32)
REQ-027 SHALL check ADD: op=0010, a=0xFFFFFFFF, b=1 -> valid 1 cycle after accept, y=0, cout=1, zf=1, err=0.
REQ-028 SHALL check SLT: op=0111, a=0xFFFFFFFF, b=1 -> y=1, yhi=0; op=0110, a=5, b=5 -> y=0, zf=1, cout=1.
REQ-029 SHALL check MULU: a=0xFFFFFFFF, b=2 -> yhi=1, y=0xFFFFFFFE, valid exactly 33 cycles after accept, ready=0 throughout, start pulses during BUSY ignored.
REQ-030 SHALL check DIVU (macro defined): a=100, b=7 -> y=14, yhi=2, err=0; a=100, b=0 -> y=0xFFFFFFFF, yhi=100, err=1; macro undefined: op 1001 -> y=0, err=1, latency 1.
REQ-031 SHALL check reset mid-MULU: reset_n low at cycle 10 of BUSY -> y=yhi=0, valid never pulses, ready=1; after release a new ADD 2+3 -> y=5.
REQ-032 SHALL check illegal op 1100, a=3, b=4 -> valid 1 cycle after accept, y=yhi=0, zf=1, err=1; next legal op clears err.
